// File: rtl/pio_in_pkg.sv
// -----------------------------------------------------------------------------
// pio_in_pkg
// Shared constants for the debounced Avalon-MM input port:
//   - word offsets of the register map
//   - address width of the slave port
//   - default values for the debounce prescaler and threshold parameters
// -----------------------------------------------------------------------------
package pio_in_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_RAW      = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_THRESH   = 3'd6;

    // 1 ms debounce tick at 50 MHz, ten ticks of stability by default.
    localparam int DEF_DB_PRESCALE   = 50000;
    localparam int DEF_DB_THRESH_RST = 10;

endpackage : pio_in_pkg

// File: rtl/pio_in_db_cell.sv
// -----------------------------------------------------------------------------
// pio_in_db_cell
// One input channel: synchroniser chain, stable value S and debounce counter.
// Build option: PIO_IN_DEBOUNCE_EN. When undefined, S is the synchroniser
// output directly and tick_i/thresh_i/armed_i are not used.
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   in_i      in   asynchronous pin input
//   tick_i    in   one-cycle debounce tick from the shared prescaler
//   thresh_i  in   required number of stable ticks (0 = bypass)
//   armed_i   in   low during the post-reset settling window
//   raw_o     out  synchroniser output
//   s_o       out  debounced stable value
// -----------------------------------------------------------------------------
module pio_in_db_cell #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_i,
    input  logic                tick_i,
    input  logic [DB_CNT_W-1:0] thresh_i,
    input  logic                armed_i,
    output logic                raw_o,
    output logic                s_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
        end
    end

    assign raw_o = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    logic                s_q, s_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic [DB_CNT_W:0]   cnt_inc;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        s_d     = s_q;
        cnt_d   = cnt_q;
        cnt_inc = {1'b0, cnt_q} + 1'b1;
        if (!armed_i) begin
            // Settling window: track the input so the armed state starts equal.
            s_d   = raw_o;
            cnt_d = '0;
        end else if (raw_o == s_q) begin
            cnt_d = '0;
        end else if (thresh_i == '0) begin
            s_d   = raw_o;
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_inc >= {1'b0, thresh_i}) begin
                s_d   = raw_o;
                cnt_d = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_inc[DB_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            s_q   <= s_d;
            cnt_q <= cnt_d;
        end
    end

    assign s_o = s_q;
`else
    logic unused_db;
    assign unused_db = ^{tick_i, thresh_i, armed_i};
    assign s_o       = raw_o;
`endif

endmodule : pio_in_db_cell

// File: rtl/pio_in_debounce.sv
// -----------------------------------------------------------------------------
// pio_in_debounce
// Avalon-MM input port for board switches/keys: per-channel synchroniser and
// debounce filter, per-bit rise/fall edge capture (write-1-to-clear) and a
// level interrupt. Build option: PIO_IN_DEBOUNCE_EN enables the prescaler,
// debounce counters and THRESH register; without it S follows RAW and THRESH
// reads 0.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   address     in   word address
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data
//   readdata    out  registered read data (1-cycle latency, chipselect-free)
//   in_port     in   asynchronous switch inputs
//   irq         out  level interrupt, |(EDGE_CAP & IRQ_MASK)
// -----------------------------------------------------------------------------
module pio_in_debounce
    import pio_in_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CNT_W      = 4,
    parameter int DB_PRESCALE   = DEF_DB_PRESCALE,
    parameter int DB_THRESH_RST = DEF_DB_THRESH_RST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    localparam int ARM_CNT = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_CNT + 1);

    logic [ARM_W-1:0]    arm_q;
    logic                armed;
    logic                wr_en;
    logic                tick;
    logic [DB_CNT_W-1:0] thresh;
    logic [31:0]         thresh_rd;

    logic [WIDTH-1:0] raw, s;
    logic [WIDTH-1:0] rise, fall, edge_set, edge_clr;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] s_prev_q, s_prev_d;
    logic [31:0]      readdata_q, readdata_d;

    assign wr_en = chipselect & ~write_n;
    assign armed = (arm_q == ARM_W'(ARM_CNT));

    // Arming window: long enough for the synchronisers to fill and S to load.
    always_ff @(posedge clk) begin
        if (reset) begin
            arm_q <= '0;
        end else if (!armed) begin
            arm_q <= arm_q + 1'b1;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int PRE_W = (DB_PRESCALE > 1) ? $clog2(DB_PRESCALE) : 1;

    logic [PRE_W-1:0]    presc_q;
    logic [DB_CNT_W-1:0] thresh_q;
    logic                unused_wd;

    assign tick      = (presc_q == PRE_W'(DB_PRESCALE - 1));
    assign thresh    = thresh_q;
    assign thresh_rd = 32'(thresh_q);
    assign unused_wd = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= '0;
            thresh_q <= DB_CNT_W'(DB_THRESH_RST);
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (wr_en && address == ADDR_THRESH) begin
                thresh_q <= writedata[DB_CNT_W-1:0];
            end
        end
    end
`else
    logic unused_cfg;

    assign tick       = 1'b0;
    assign thresh     = '0;
    assign thresh_rd  = '0;
    assign unused_cfg = ^writedata ^ (DB_PRESCALE == 0) ^ (DB_THRESH_RST == 0);
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        pio_in_db_cell #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CNT_W    (DB_CNT_W)
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .in_i     (in_port[i]),
            .tick_i   (tick),
            .thresh_i (thresh),
            .armed_i  (armed),
            .raw_o    (raw[i]),
            .s_o      (s[i])
        );
    end

    // While unarmed the previous-S register also tracks RAW, so the first
    // armed comparison sees S == S_d even for inputs held active at reset.
    assign s_prev_d = armed ? s : raw;
    assign rise     = s & ~s_prev_q & rise_en_q;
    assign fall     = ~s & s_prev_q & fall_en_q;
    assign edge_set = armed ? (rise | fall) : '0;
    assign edge_clr = (wr_en && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
    // Set is OR-ed after the clear so a new edge wins over a same-cycle clear.
    assign edge_cap_d = (edge_cap_q & ~edge_clr) | edge_set;

    always_comb begin
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        if (wr_en) begin
            case (address)
                ADDR_IRQ_MASK: irq_mask_d = writedata[WIDTH-1:0];
                ADDR_RISE_EN:  rise_en_d  = writedata[WIDTH-1:0];
                ADDR_FALL_EN:  fall_en_d  = writedata[WIDTH-1:0];
                default:       ;
            endcase
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d = 32'(s);
            ADDR_RAW:      readdata_d = 32'(raw);
            ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
            ADDR_EDGE_CAP: readdata_d = 32'(edge_cap_q);
            ADDR_RISE_EN:  readdata_d = 32'(rise_en_q);
            ADDR_FALL_EN:  readdata_d = 32'(fall_en_q);
            ADDR_THRESH:   readdata_d = thresh_rd;
            default:       readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask_q <= '0;
            rise_en_q  <= '1;
            fall_en_q  <= '0;
            edge_cap_q <= '0;
            s_prev_q   <= '0;
            readdata_q <= '0;
        end else begin
            irq_mask_q <= irq_mask_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            edge_cap_q <= edge_cap_d;
            s_prev_q   <= s_prev_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule : pio_in_debounce

// File: tb/tb_pio_in_debounce.sv
// -----------------------------------------------------------------------------
// tb_pio_in_debounce
// Directed self-checking bench for pio_in_debounce (WIDTH=3, DB_PRESCALE=4).
// Read expectations are queued when a read is issued and compared when the
// registered readdata appears one cycle later.
// -----------------------------------------------------------------------------
module tb_pio_in_debounce;
    import pio_in_pkg::*;

`ifdef PIO_IN_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
    localparam int SET_LAT = 3;   // THRESH=0: raw at e2, S at e3, capture at e4
`else
    localparam bit DB_ON = 1'b0;
    localparam int SET_LAT = 2;   // S=raw at e2, capture at e3
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [2:0]        in_port = 3'b101;
    logic              irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    pio_in_debounce #(
        .WIDTH         (3),
        .SYNC_STAGES   (2),
        .DB_CNT_W      (4),
        .DB_PRESCALE   (4),
        .DB_THRESH_RST (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic cycle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] e, input string tag);
        logic [31:0] exp_v;
        string       tag_v;
        address = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        tag_v = tag_q.pop_front();
        checks++;
        assert (readdata === exp_v) else begin
            errors++;
            $error("FAIL %s: readdata=%0h expected=%0h", tag_v, readdata, exp_v);
        end
    endtask

    task automatic chk_irq(input logic e, input string tag);
        checks++;
        assert (irq === e) else begin
            errors++;
            $error("FAIL %s: irq=%b expected=%b", tag, irq, e);
        end
    endtask

    initial begin
        // Reset with inputs already asserted.
        cycle(3);
        rd(ADDR_DATA, 32'd0, "readdata_in_reset");
        chk_irq(1'b0, "irq_in_reset");
        reset = 1'b0;
        cycle(10);
        rd(ADDR_DATA,     32'd5, "data_after_arm");
        rd(ADDR_RAW,      32'd5, "raw_after_arm");
        rd(ADDR_EDGE_CAP, 32'd0, "edge_cap_no_spurious");
        rd(ADDR_IRQ_MASK, 32'd0, "irq_mask_rst");
        rd(ADDR_RISE_EN,  32'd7, "rise_en_rst");
        rd(ADDR_FALL_EN,  32'd0, "fall_en_rst");
        rd(ADDR_THRESH,   DB_ON ? 32'd10 : 32'd0, "thresh_rst");
        rd(3'd7,          32'd0, "unmapped_rd");
        chk_irq(1'b0, "irq_after_arm");

        // Register access, upper bits, writes to RO ignored.
        wr(ADDR_THRESH, 32'd3);
        rd(ADDR_THRESH, DB_ON ? 32'd3 : 32'd0, "thresh_wr3");
        wr(ADDR_IRQ_MASK, 32'hFFFF_FFFF);
        rd(ADDR_IRQ_MASK, 32'd7, "irq_mask_upper_bits");
        wr(ADDR_DATA, 32'd0);
        rd(ADDR_DATA, 32'd5, "data_ro");

        // Falling edge on bit0 with FALL_EN=0: no capture.
        in_port = 3'b100;
        cycle(20);
        rd(ADDR_DATA,     32'd4, "data_bit0_low");
        rd(ADDR_EDGE_CAP, 32'd0, "no_fall_capture");
        chk_irq(1'b0, "irq_no_fall");

        // Rising edge on bit0; with THRESH=3 and tick every 4 cycles, S
        // changes between edges 11 and 14 after the pin change.
        in_port = 3'b101;
        cycle(10);
        rd(ADDR_DATA, DB_ON ? 32'd4 : 32'd5, "data_before_thresh");
        cycle(3);
        rd(ADDR_DATA, 32'd5, "data_after_thresh");
        cycle(5);
        rd(ADDR_EDGE_CAP, 32'd1, "edge_cap_rise0");
        chk_irq(1'b1, "irq_rise0");
        wr(ADDR_IRQ_MASK, 32'd0);
        chk_irq(1'b0, "irq_masked");
        wr(ADDR_IRQ_MASK, 32'd7);
        chk_irq(1'b1, "irq_unmasked");
        wr(ADDR_EDGE_CAP, 32'd1);
        chk_irq(1'b0, "irq_deassert_after_clear");
        rd(ADDR_EDGE_CAP, 32'd0, "edge_cap_cleared");

        // Bounce on bit1: toggle every 5 cycles for 40 cycles, then settle high.
        for (int ph = 0; ph < 8; ph++) begin
            in_port[1] = ~in_port[1];
`ifdef PIO_IN_DEBOUNCE_EN
            for (int k = 0; k < 5; k++) rd(ADDR_DATA, 32'd5, "data_during_bounce");
`else
            cycle(5);
`endif
        end
`ifdef PIO_IN_DEBOUNCE_EN
        rd(ADDR_EDGE_CAP, 32'd0, "edge_cap_during_bounce");
`endif
        in_port = 3'b111;
        cycle(20);
        rd(ADDR_DATA,     32'd7, "data_after_settle");
        rd(ADDR_EDGE_CAP, 32'd2, "edge_cap_after_settle");
        wr(ADDR_EDGE_CAP, 32'd7);
        rd(ADDR_EDGE_CAP, 32'd0, "edge_cap_clear_all");

        // Fall-only on bit2.
        wr(ADDR_FALL_EN, 32'd4);
        wr(ADDR_RISE_EN, 32'd0);
        rd(ADDR_EDGE_CAP, 32'd0, "en_change_keeps_cap");
        in_port = 3'b011;
        cycle(20);
        rd(ADDR_EDGE_CAP, 32'd4, "edge_cap_fall2");
        rd(ADDR_DATA,     32'd3, "data_fall2");
        wr(ADDR_EDGE_CAP, 32'd4);
        in_port = 3'b111;
        cycle(20);
        rd(ADDR_EDGE_CAP, 32'd0, "no_rise_capture");
        chk_irq(1'b0, "irq_no_rise");

        // Partial clear of EDGE_CAP=3'b011.
        wr(ADDR_RISE_EN, 32'd7);
        wr(ADDR_FALL_EN, 32'd0);
        in_port = 3'b100;
        cycle(20);
        in_port = 3'b111;
        cycle(20);
        rd(ADDR_EDGE_CAP, 32'd3, "edge_cap_011");
        wr(ADDR_EDGE_CAP, 32'd1);
        rd(ADDR_EDGE_CAP, 32'd2, "edge_cap_partial_clear");
        chk_irq(1'b1, "irq_partial_clear");

        // Reset mid-operation returns everything to reset values, no spurious edge.
        reset = 1'b1;
        cycle(1);
        reset = 1'b0;
        chk_irq(1'b0, "irq_after_midreset");
        rd(ADDR_EDGE_CAP, 32'd0, "edge_cap_after_midreset");
        cycle(10);
        rd(ADDR_DATA,     32'd7, "data_rearmed");
        rd(ADDR_EDGE_CAP, 32'd0, "edge_cap_rearmed");
        rd(ADDR_IRQ_MASK, 32'd0, "irq_mask_midreset");
        rd(ADDR_RISE_EN,  32'd7, "rise_en_midreset");
        rd(ADDR_THRESH,   DB_ON ? 32'd10 : 32'd0, "thresh_midreset");

        // Set wins over a same-cycle clear on bit1 (THRESH=0 bypass).
        wr(ADDR_IRQ_MASK, 32'd7);
        wr(ADDR_THRESH, 32'd0);
        in_port = 3'b101;
        cycle(10);
        rd(ADDR_EDGE_CAP, 32'd0, "no_cap_before_set_wins");
        in_port = 3'b111;
        cycle(SET_LAT);
        wr(ADDR_EDGE_CAP, 32'd2);
        rd(ADDR_EDGE_CAP, 32'd2, "set_wins_over_clear");
        chk_irq(1'b1, "irq_set_wins");
        wr(ADDR_EDGE_CAP, 32'd2);
        rd(ADDR_EDGE_CAP, 32'd0, "clear_after_set_wins");
        chk_irq(1'b0, "irq_after_final_clear");

        // THRESH=0: DATA follows RAW with one cycle of lag.
        in_port = 3'b101;
        cycle(2);
        rd(ADDR_DATA, DB_ON ? 32'd7 : 32'd5, "data_lag_first");
        rd(ADDR_DATA, 32'd5, "data_lag_second");
        rd(ADDR_RAW,  32'd5, "raw_lag");

        wr(ADDR_THRESH, 32'd7);
        rd(ADDR_THRESH, DB_ON ? 32'd7 : 32'd0, "thresh_wr7");
        chk_irq(1'b0, "irq_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pio_in_debounce
